// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller for the 5-stage MIPS pipeline.
// Drives PC and pipeline-register enables/flushes, plus debug counters.
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_dREN,
    input  logic [4:0]       ex_wsel,
    input  logic             ex_redirect,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_ihit_seen;
    logic             w_ihit_seen_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_dstall;
    logic w_lu;
    logic w_ih;
    logic w_stall_ev;
    logic w_flush_ev;

    logic w_pc_en;
    logic w_ifid_en;
    logic w_idex_en;
    logic w_exmem_en;
    logic w_memwb_en;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_exmem_flush;

    assign w_dstall = (mem_dREN | mem_dWEN) & ~dhit;
    assign w_lu     = ex_dREN & (ex_wsel != 5'd0)
                    & ((ex_wsel == id_rs)
                       | (id_uses_rt & (ex_wsel == id_rt)));
    // A hit seen during a data stall stays valid: IF holds imemload while PC is frozen.
    assign w_ih     = ihit | r_ihit_seen;

    // Next-state, hazard resolution and raw enable/flush generation.
    always_comb begin
        w_next          = r_state;
        w_ihit_seen_nxt = r_ihit_seen;
        w_stall_ev      = 1'b0;
        w_flush_ev      = 1'b0;
        w_pc_en         = 1'b0;
        w_ifid_en       = 1'b0;
        w_idex_en       = 1'b0;
        w_exmem_en      = 1'b0;
        w_memwb_en      = 1'b0;
        w_ifid_flush    = 1'b0;
        w_idex_flush    = 1'b0;
        w_exmem_flush   = 1'b0;
        if (!RST && r_state != HALT) begin
            if (wb_halt) begin
                w_next = HALT;
            end else if (w_dstall) begin
                w_next          = DWAIT;
                w_stall_ev      = 1'b1;
                w_ihit_seen_nxt = r_ihit_seen | ihit;
            end else begin
                w_next          = RUN;
                w_ihit_seen_nxt = 1'b0;
                if (ex_redirect && w_ih) begin
                    w_pc_en      = 1'b1;
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                    w_exmem_en   = 1'b1;
                    w_memwb_en   = 1'b1;
                    w_flush_ev   = 1'b1;
                end else if (ex_redirect) begin
                    w_exmem_flush = 1'b1;
                    w_memwb_en    = 1'b1;
                    w_stall_ev    = 1'b1;
                end else if (w_lu || !w_ih) begin
                    w_idex_flush = 1'b1;
                    w_exmem_en   = 1'b1;
                    w_memwb_en   = 1'b1;
                    w_stall_ev   = 1'b1;
                end else begin
                    w_pc_en    = 1'b1;
                    w_ifid_en  = 1'b1;
                    w_idex_en  = 1'b1;
                    w_exmem_en = 1'b1;
                    w_memwb_en = 1'b1;
                end
            end
        end
    end

    // State and latched-ihit registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= RUN;
            r_ihit_seen <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_ihit_seen <= w_ihit_seen_nxt;
        end
    end

    // Saturating stall and flush event counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_ev && r_stall_cnt != {CNT_W{1'b1}})
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_ev && r_flush_cnt != {CNT_W{1'b1}})
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    // A flushed register never also captures.
    assign pc_en       = w_pc_en;
    assign ifid_en     = w_ifid_en & ~w_ifid_flush;
    assign idex_en     = w_idex_en & ~w_idex_flush;
    assign exmem_en    = w_exmem_en & ~w_exmem_flush;
    assign memwb_en    = w_memwb_en;
    assign ifid_flush  = w_ifid_flush;
    assign idex_flush  = w_idex_flush;
    assign exmem_flush = w_exmem_flush;
    assign halted      = (r_state == HALT);
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed self-checking bench for pipeline_ctrl.
// Outputs packed as {pc,ifid,idex,exmem,memwb en, ifid,idex,exmem flush}.
module tb_pipeline_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ihit, dhit, mem_dREN, mem_dWEN;
    logic [4:0] id_rs, id_rt, ex_wsel;
    logic       id_uses_rt, ex_dREN, ex_redirect, wb_halt;

    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, halted;
    logic [31:0] stall_cnt, flush_cnt;

    logic        pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4;
    logic        ifid_flush4, idex_flush4, exmem_flush4, halted4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    pipeline_ctrl #(.CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_dREN(ex_dREN), .ex_wsel(ex_wsel),
        .ex_redirect(ex_redirect), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_dREN(ex_dREN), .ex_wsel(ex_wsel),
        .ex_redirect(ex_redirect), .wb_halt(wb_halt),
        .pc_en(pc_en4), .ifid_en(ifid_en4), .idex_en(idex_en4),
        .exmem_en(exmem_en4), .memwb_en(memwb_en4),
        .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
        .exmem_flush(exmem_flush4), .halted(halted4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    wire [7:0] outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                       ifid_flush, idex_flush, exmem_flush};

    localparam logic [7:0] ALL_EN = 8'b11111_000;
    localparam logic [7:0] NONE   = 8'b00000_000;
    localparam logic [7:0] LU     = 8'b00011_010;
    localparam logic [7:0] RD_HIT = 8'b10011_110;
    localparam logic [7:0] RD_MIS = 8'b00001_001;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_dREN = 1'b0; ex_wsel = 5'd0; ex_redirect = 1'b0;
        wb_halt = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        idle();
        tick();
        #1 check("rst_outs", {24'd0, outs}, {24'd0, NONE});
        tick();
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_stall", stall_cnt, 32'd0);
        check("rst_flush", flush_cnt, 32'd0);
        check("rst_outs2", {24'd0, outs}, {24'd0, NONE});

        RST = 1'b0;
        #1 check("start", {24'd0, outs}, {24'd0, ALL_EN});
        tick();

        ex_dREN = 1'b1; ex_wsel = 5'd8; id_rs = 5'd8;
        #1 check("lu_rs", {24'd0, outs}, {24'd0, LU});
        tick();
        check("lu_cnt", stall_cnt, 32'd1);

        ex_wsel = 5'd0; id_rs = 5'd0;
        #1 check("lu_r0", {24'd0, outs}, {24'd0, ALL_EN});
        tick();
        check("lu_r0_cnt", stall_cnt, 32'd1);

        ex_wsel = 5'd5; id_rt = 5'd5; id_rs = 5'd1; id_uses_rt = 1'b0;
        #1 check("rt_unused", {24'd0, outs}, {24'd0, ALL_EN});
        id_uses_rt = 1'b1;
        #1 check("lu_rt", {24'd0, outs}, {24'd0, LU});
        tick();
        check("lu_rt_cnt", stall_cnt, 32'd2);
        idle();

        ex_redirect = 1'b1;
        #1 check("rd_hit", {24'd0, outs}, {24'd0, RD_HIT});
        tick();
        check("rd_hit_fcnt", flush_cnt, 32'd1);

        ihit = 1'b0;
        #1 check("rd_miss", {24'd0, outs}, {24'd0, RD_MIS});
        tick();
        check("rd_miss_scnt", stall_cnt, 32'd3);
        check("rd_miss_fcnt", flush_cnt, 32'd1);

        ihit = 1'b1; ex_dREN = 1'b1; ex_wsel = 5'd9; id_rs = 5'd9;
        #1 check("rd_lu", {24'd0, outs}, {24'd0, RD_HIT});
        tick();
        check("rd_lu_fcnt", flush_cnt, 32'd2);
        check("rd_lu_scnt", stall_cnt, 32'd3);
        idle();

        ihit = 1'b0;
        #1 check("imiss", {24'd0, outs}, {24'd0, LU});
        tick();
        check("imiss_cnt", stall_cnt, 32'd4);

        mem_dREN = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            ihit = (c == 2);
            #1 check($sformatf("dwait%0d", c), {24'd0, outs}, {24'd0, NONE});
            tick();
        end
        check("dwait_cnt", stall_cnt, 32'd7);
        dhit = 1'b1; ihit = 1'b0;
        #1 check("dwait_done", {24'd0, outs}, {24'd0, ALL_EN});
        tick();
        check("dwait_done_cnt", stall_cnt, 32'd7);
        mem_dREN = 1'b0;
        #1 check("seen_clr", {24'd0, outs}, {24'd0, LU});
        tick();
        check("seen_clr_cnt", stall_cnt, 32'd8);
        idle();

        mem_dREN = 1'b1; wb_halt = 1'b1;
        #1 check("halt_now", {24'd0, outs}, {24'd0, NONE});
        check("halt_not_yet", {31'd0, halted}, 32'd0);
        tick();
        check("halted", {31'd0, halted}, 32'd1);
        check("halt_scnt", stall_cnt, 32'd8);
        idle();
        ex_redirect = 1'b1;
        #1 check("halt_outs", {24'd0, outs}, {24'd0, NONE});
        tick();
        check("halt_sticky", {31'd0, halted}, 32'd1);
        check("halt_fcnt", flush_cnt, 32'd2);
        check("halt_scnt2", stall_cnt, 32'd8);
        idle();

        RST = 1'b1;
        tick();
        check("rst_halt", {31'd0, halted}, 32'd0);
        check("rst_halt_scnt", stall_cnt, 32'd0);
        RST = 1'b0;

        ex_dREN = 1'b1; ex_wsel = 5'd3; id_rs = 5'd3;
        repeat (20) tick();
        check("sat4", {28'd0, stall_cnt4}, 32'd15);
        check("sat32", stall_cnt, 32'd20);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the 5-stage pipelined MIPS core. It generates the enable and flush inputs that the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC consume. It resolves instruction-fetch waits, data-memory waits, load-use hazards, EX-stage control redirects and halt. It also latches instruction hits that arrive during data stalls and keeps stall and flush event counters for debug.

## Interface
- CNT_W, 32, width of the stall and flush counters
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- ihit  in  1  instruction memory returned a valid word for the current PC
- dhit  in  1  data memory completed the access of the instruction in MEM
- mem_dREN, mem_dWEN  in  1 each  load/store in MEM (EX/MEM register outputs)
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_dREN  in  1  instruction in EX is a load (ID/EX register output)
- ex_wsel  in  5  destination register of the instruction in EX
- ex_redirect  in  1  taken branch, j, jal or jr resolved in EX
- wb_halt  in  1  halt flag at the MEM/WB register output
- pc_en  out  1  PC loads its next value
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register captures its inputs
- ifid_flush, idex_flush, exmem_flush  out  1 each  register loads all-zero (bubble)
- halted  out  1  core halted, sticky
- stall_cnt  out  CNT_W  cycles with any stall
- flush_cnt  out  CNT_W  redirect flushes issued

## Operation
- States: RUN, DWAIT, HALT. Internal flag ihit_seen.
- dstall = (mem_dREN | mem_dWEN) & ~dhit.
- lu = ex_dREN & (ex_wsel != 0) & ((ex_wsel == id_rs) | (id_uses_rt & ex_wsel == id_rt)).
- ih = ihit | ihit_seen.
- Outputs are combinational from the state and the inputs.
- Priority in RUN/DWAIT, first match wins:
  1. wb_halt: all enables 0, all flushes 0. Next state is HALT.
  2. dstall: all enables 0, all flushes 0 (freeze). Next state is DWAIT. stall_cnt++. ihit_seen <= ihit_seen | ihit.
  3. ex_redirect & ih: pc_en=1, ifid_flush=1, idex_flush=1, exmem_en=1, memwb_en=1. flush_cnt++.
  4. ex_redirect & ~ih: pc_en=0, ifid_en=0, idex_en=0, exmem_flush=1, memwb_en=1. stall_cnt++.
  5. lu | ~ih: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1. stall_cnt++.
  6. Otherwise: all enables 1, all flushes 0.
- Any cycle that matches rules 3-6 clears ihit_seen and sets the next state to RUN.
- Any asserted flush forces the matching enable to 0.
- The IF stage keeps imemload stable while pc_en=0, so a latched hit (ihit_seen=1) stays valid.
- HALT: all enables 0, all flushes 0, halted=1, and the counters freeze. Only RST leaves HALT.
- Counters saturate at all-ones and do not wrap.

## Timing
- RST=1 at an edge sets the following: state RUN, ihit_seen 0, halted 0, stall_cnt 0, flush_cnt 0.
- While RST=1, all enables and flushes are forced to 0.
- halted is a registered output. It goes to 1 in the cycle after wb_halt is sampled in RUN/DWAIT.
- Enable and flush outputs have zero latency from the inputs.
- Counters reflect a cycle's event at the next edge.
- wb_halt together with dstall resolves to halt; no stall is counted.
- ex_redirect together with lu resolves as a redirect, because the ID instruction is flushed.
- An ihit that arrives during a dstall cycle is never lost. It is honoured on the first non-dstall cycle even if ihit=0 in that cycle.
- RST asserted mid-DWAIT or in HALT returns to RUN on the next edge.

## Test plan
- Reset and start: hold RST=1 for 2 cycles with ihit=1.
  - During reset: all enables 0, halted 0, counters 0.
  - First cycle after release with ihit=1: all enables 1.
- Load-use: ex_dREN=1, ex_wsel=8, id_rs=8, ihit=1.
  - Response: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1; stall_cnt goes 0->1.
  - Repeat with ex_wsel=0: all enables 1, no stall counted.
- Redirect:
  - ex_redirect=1, ihit=1: pc_en=1, ifid_flush=1, idex_flush=1; flush_cnt goes 0->1.
  - Same with ihit=0: idex_en=0, exmem_flush=1, memwb_en=1, pc_en=0.
- Data wait: mem_dREN=1, dhit=0 for 3 cycles, ihit=1 only in cycle 2, then dhit=1 in cycle 4 with ihit=0.
  - Cycles 1-3: all enables 0, state DWAIT.
  - Cycle 4: all enables 1.
  - stall_cnt advances by 3.
- Halt: wb_halt=1 with a pending dstall.
  - Same cycle: all enables 0.
  - Next cycle: halted=1, which persists after wb_halt drops; counters unchanged.
  - RST clears halted.
- Saturation: CNT_W=4, 20 consecutive load-use cycles -> stall_cnt holds 15.
